// File: rtl/rv_lsu_pkg.sv
// Shared types and helpers for the RV32I MEM-stage load/store unit.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } lsu_state_e;

  // Everything about the in-flight access that outlives the EX/MEM register.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] lo;
    logic [4:0] rd;
  } lsu_op_t;

  function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
    if (ld) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Clear the low address bits below the access size (natural alignment).
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return lo;
      2'b01:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction with sign/zero extension for LB/LH/LW/LBU/LHU.
module lsu_load_align
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*addr_lo +: 8];
    h = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I MEM-stage LSU: req/gnt/rvalid handshake to data memory, pipeline stall, load writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating them.
module lsu_mem_stage
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN/8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic            ex_ld_i,
  input  logic            ex_st_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic [4:0]      ex_rd_i,
  output logic            lsu_stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [BE_W-1:0] dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o
);

  lsu_state_e                 state_q;
  lsu_op_t                    op_q;
  logic                       acc, legal, issue;
  logic [1:0]                 lo;
  logic [BE_W-1:0][7:0]       st_lane;
  logic [XLEN-1:0]            ld_data;

  assign acc   = ex_valid_i & (ex_ld_i | ex_st_i);
  assign legal = f3_legal(ex_ld_i, ex_funct3_i);
  assign lo    = align_lo(ex_funct3_i, ex_addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis   = acc & legal & f3_misaligned(ex_funct3_i, ex_addr_i[1:0]);
  assign issue = acc & legal & ~mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= (state_q == S_IDLE) & mis;
  end
`else
  assign issue      = acc & legal;
  assign misalign_o = 1'b0;
`endif

  // Byte/halfword stores replicate across all lanes so the byte enables alone pick the target.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign st_lane[i] = (ex_funct3_i[1:0] == 2'b00) ? ex_wdata_i[7:0] :
                        (ex_funct3_i[1:0] == 2'b01) ? ex_wdata_i[8*(i%2) +: 8] :
                                                      ex_wdata_i[8*i +: 8];
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .funct3  (op_q.funct3),
    .addr_lo (op_q.lo),
    .rdata   (dmem_rdata_i),
    .data    (ld_data)
  );

  always_comb begin
    lsu_stall_o = 1'b0;
    case (state_q)
      S_IDLE:  lsu_stall_o = issue;
      S_REQ:   lsu_stall_o = !(op_q.we && dmem_gnt_i);
      S_RESP:  lsu_stall_o = !dmem_rvalid_i;
      default: lsu_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: if (issue) begin
          op_q         <= '{we: ex_st_i, funct3: ex_funct3_i, lo: lo, rd: ex_rd_i};
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= ex_st_i;
          dmem_addr_o  <= {ex_addr_i[XLEN-1:2], 2'b00};
          dmem_be_o    <= lane_be(ex_funct3_i, lo);
          dmem_wdata_o <= ex_st_i ? st_lane : '0;
          state_q      <= S_REQ;
        end
        S_REQ: if (dmem_gnt_i) begin
          dmem_req_o   <= 1'b0;
          dmem_we_o    <= 1'b0;
          dmem_addr_o  <= '0;
          dmem_be_o    <= '0;
          dmem_wdata_o <= '0;
          state_q      <= op_q.we ? S_IDLE : S_RESP;
        end
        S_RESP: if (dmem_rvalid_i) begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= op_q.rd;
          wb_data_o  <= ld_data;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: bench acts as EX/MEM driver and data memory.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 0, ex_ld_i = 0, ex_st_i = 0;
  logic [2:0]  ex_funct3_i = '0;
  logic [31:0] ex_addr_i = '0, ex_wdata_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        lsu_stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic [31:0] dmem_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ld_i(ex_ld_i), .ex_st_i(ex_st_i),
    .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_rd_i(ex_rd_i), .lsu_stall_o(lsu_stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} mreq_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;

  mreq_t req_sb[$];
  wb_t   wb_sb[$];
  mreq_t er;
  wb_t   ew;
  int    n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[31:2] == 30'h40) ? 32'h1234ABCD : ~a;
  endfunction

  // Scoreboard consumers: granted requests and writebacks.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_o && dmem_gnt_i) begin
        if (req_sb.size() == 0) chk("req_unexp", dmem_req_o, 0);
        else begin
          er = req_sb.pop_front();
          chk("req_we", dmem_we_o, er.we);
          chk("req_addr", dmem_addr_o, er.addr);
          chk("req_be", dmem_be_o, er.be);
          if (er.we) chk("req_wdata", dmem_wdata_o, er.wdata);
        end
      end
      if (wb_valid_o) begin
        if (wb_sb.size() == 0) chk("wb_unexp", wb_valid_o, 0);
        else begin
          ew = wb_sb.pop_front();
          chk("wb_rd", wb_rd_o, ew.rd);
          chk("wb_data", wb_data_o, ew.data);
        end
      end
    end
  end

  task automatic run_op(input string nm, input logic ld, st, input logic [2:0] f3,
                        input logic [31:0] a, wd, input logic [4:0] rd, input int gd, rvd,
                        input logic iss, input logic [3:0] ebe, input logic [31:0] ewd, edata,
                        input logic emis);
    int cyc, req_seen, gnt_cyc, stalls, exp_st;
    bit done;
    logic [31:0] ea;
    cyc = 0; req_seen = 0; gnt_cyc = -1; stalls = 0; done = 0;
    ea = {a[31:2], 2'b00};
    exp_st = !iss ? 0 : (st ? 1 + gd : 1 + gd + rvd);
    if (iss) begin
      req_sb.push_back('{we: st, addr: ea, be: ebe, wdata: ewd});
      if (ld) wb_sb.push_back('{rd: rd, data: edata});
    end
    @(posedge clk); #1;
    ex_valid_i = 1; ex_ld_i = ld; ex_st_i = st; ex_funct3_i = f3;
    ex_addr_i = a; ex_wdata_i = wd; ex_rd_i = rd;
    while (!done && cyc < 40) begin
      dmem_gnt_i    = dmem_req_o && (req_seen >= gd);
      // spurious rvalid while still waiting for grant must be ignored
      dmem_rvalid_i = ((gnt_cyc >= 0) && (cyc - gnt_cyc == rvd)) ||
                      (dmem_req_o && !dmem_gnt_i && gd > 2);
      dmem_rdata_i  = dmem_rvalid_i ? mem_word(ea) : $urandom;
      if (dmem_req_o) chk({nm, "/req_addr_hold"}, dmem_addr_o, ea);
      #1;
      if (lsu_stall_o) stalls++; else done = 1;
      if (dmem_req_o) req_seen++;
      if (dmem_gnt_i) gnt_cyc = cyc;
      cyc++;
      if (!done) begin @(posedge clk); #1; end
    end
    chk({nm, "/done"}, done, 1);
    chk({nm, "/stalls"}, stalls, exp_st);
    @(posedge clk); #1;
    ex_valid_i = 0; ex_ld_i = 0; ex_st_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    #1;
    chk({nm, "/misalign"}, misalign_o, emis);
    chk({nm, "/idle_req"}, dmem_req_o, 0);
    @(posedge clk); #1;
    chk({nm, "/sb_drain"}, req_sb.size() + wb_sb.size(), 0);
    chk({nm, "/misalign_clr"}, misalign_o, 0);
  endtask

  initial begin
    #12;
    chk("rst/stall", lsu_stall_o, 0);
    chk("rst/req", dmem_req_o, 0);
    chk("rst/be", dmem_be_o, 0);
    chk("rst/wb_valid", wb_valid_o, 0);
    chk("rst/misalign", misalign_o, 0);
    @(negedge clk); rst = 0;

    //      name      ld st f3      addr      wdata         rd gd rvd iss be    exp wdata     exp load      mis
    run_op("sw",      0, 1, 3'b010, 32'h190, 32'h1234ABCD, 0,  0, 1,  1, 4'hF, 32'h1234ABCD, 32'h0,        0);
    run_op("lw",      1, 0, 3'b010, 32'h100, 32'h0,        5,  0, 1,  1, 4'hF, 32'h0,        32'h1234ABCD, 0);
    run_op("lh_hi",   1, 0, 3'b001, 32'h102, 32'h0,        6,  0, 1,  1, 4'hC, 32'h0,        32'h00001234, 0);
    run_op("lhu_hi",  1, 0, 3'b101, 32'h102, 32'h0,        7,  0, 1,  1, 4'hC, 32'h0,        32'h00001234, 0);
    run_op("lh_lo",   1, 0, 3'b001, 32'h100, 32'h0,        8,  0, 1,  1, 4'h3, 32'h0,        32'hFFFFABCD, 0);
    run_op("lhu_lo",  1, 0, 3'b101, 32'h100, 32'h0,        9,  0, 1,  1, 4'h3, 32'h0,        32'h0000ABCD, 0);
    run_op("lb_2",    1, 0, 3'b000, 32'h102, 32'h0,        10, 0, 1,  1, 4'h4, 32'h0,        32'h00000034, 0);
    run_op("lbu_2",   1, 0, 3'b100, 32'h102, 32'h0,        11, 0, 1,  1, 4'h4, 32'h0,        32'h00000034, 0);
    run_op("lb_0",    1, 0, 3'b000, 32'h100, 32'h0,        12, 0, 1,  1, 4'h1, 32'h0,        32'hFFFFFFCD, 0);
    run_op("lbu_0",   1, 0, 3'b100, 32'h100, 32'h0,        13, 0, 1,  1, 4'h1, 32'h0,        32'h000000CD, 0);
    run_op("lb_1",    1, 0, 3'b000, 32'h101, 32'h0,        14, 0, 1,  1, 4'h2, 32'h0,        32'hFFFFFFAB, 0);
    run_op("lbu_3",   1, 0, 3'b100, 32'h103, 32'h0,        15, 0, 1,  1, 4'h8, 32'h0,        32'h00000012, 0);
    run_op("sb_3",    0, 1, 3'b000, 32'h103, 32'h123456CD, 0,  0, 1,  1, 4'h8, 32'hCDCDCDCD, 32'h0,        0);
    run_op("sh_2",    0, 1, 3'b001, 32'h102, 32'h9999ABCD, 0,  0, 1,  1, 4'hC, 32'hABCDABCD, 32'h0,        0);
    run_op("sb_1",    0, 1, 3'b000, 32'h101, 32'h000000A5, 0,  0, 1,  1, 4'h2, 32'hA5A5A5A5, 32'h0,        0);
    run_op("sh_0",    0, 1, 3'b001, 32'h100, 32'h00001357, 0,  0, 1,  1, 4'h3, 32'h13571357, 32'h0,        0);
    run_op("lw_slow", 1, 0, 3'b010, 32'h100, 32'h0,        17, 3, 2,  1, 4'hF, 32'h0,        32'h1234ABCD, 0);
    run_op("sw_slow", 0, 1, 3'b010, 32'h190, 32'hCAFEF00D, 0,  2, 1,  1, 4'hF, 32'hCAFEF00D, 32'h0,        0);
    run_op("ld_ill3", 1, 0, 3'b011, 32'h100, 32'h0,        18, 0, 1,  0, 4'h0, 32'h0,        32'h0,        0);
    run_op("ld_ill6", 1, 0, 3'b110, 32'h100, 32'h0,        19, 0, 1,  0, 4'h0, 32'h0,        32'h0,        0);
    run_op("st_ill3", 0, 1, 3'b011, 32'h100, 32'h1,        0,  0, 1,  0, 4'h0, 32'h0,        32'h0,        0);
    run_op("st_ill4", 0, 1, 3'b100, 32'h100, 32'h1,        0,  0, 1,  0, 4'h0, 32'h0,        32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op("lw_mis",  1, 0, 3'b010, 32'h102, 32'h0,        20, 0, 1,  0, 4'h0, 32'h0,        32'h0,        1);
    run_op("lh_mis",  1, 0, 3'b001, 32'h103, 32'h0,        21, 0, 1,  0, 4'h0, 32'h0,        32'h0,        1);
    run_op("sh_mis",  0, 1, 3'b001, 32'h101, 32'h5678,     0,  0, 1,  0, 4'h0, 32'h0,        32'h0,        1);
`else
    run_op("lw_mis",  1, 0, 3'b010, 32'h102, 32'h0,        20, 0, 1,  1, 4'hF, 32'h0,        32'h1234ABCD, 0);
    run_op("lh_mis",  1, 0, 3'b001, 32'h103, 32'h0,        21, 0, 1,  1, 4'hC, 32'h0,        32'h00001234, 0);
    run_op("sh_mis",  0, 1, 3'b001, 32'h101, 32'h5678,     0,  0, 1,  1, 4'h3, 32'h56785678, 32'h0,        0);
`endif

    // reset while a load waits for its response: abandoned, no writeback
    req_sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0});
    @(posedge clk); #1;
    ex_valid_i = 1; ex_ld_i = 1; ex_funct3_i = 3'b010; ex_addr_i = 32'h100; ex_rd_i = 5'd9;
    @(posedge clk); #1;
    chk("rstr/req", dmem_req_o, 1);
    dmem_gnt_i = 1;
    @(posedge clk); #1;
    dmem_gnt_i = 0; #1;
    chk("rstr/resp_stall", lsu_stall_o, 1);
    #1; rst = 1; ex_valid_i = 0; ex_ld_i = 0; #1;
    chk("rstr/stall", lsu_stall_o, 0);
    chk("rstr/req", dmem_req_o, 0);
    chk("rstr/addr", dmem_addr_o, 0);
    chk("rstr/be", dmem_be_o, 0);
    chk("rstr/wb_valid", wb_valid_o, 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1; dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234ABCD; #1;
    chk("rstr/late_rvalid_stall", lsu_stall_o, 0);
    @(posedge clk); #1; dmem_rvalid_i = 0; #1;
    chk("rstr/no_wb", wb_valid_o, 0);
    @(posedge clk); #1;
    chk("rstr/no_wb2", wb_valid_o, 0);
    chk("rstr/sb_drain", req_sb.size() + wb_sb.size(), 0);

    // back to normal operation after the abandoned load
    run_op("lw_post", 1, 0, 3'b010, 32'h100, 32'h0, 22, 1, 1, 1, 4'hF, 32'h0, 32'h1234ABCD, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage of the 5-stage RV32I pipeline, between the EX/MEM register and the data memory port.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:
  - byte-enable and lane generation for stores;
  - lane extraction and sign/zero extension for loads.
- Runs a request/grant/response handshake to data memory and stalls the pipeline while an access is outstanding.
- Feeds load results to the MEM/WB register.

Parameters:
XLEN, 32, data and address width (only 32 supported)
BE_W, 4, byte enables per word (XLEN/8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ex_valid_i  in  1  EX/MEM holds a valid instruction
ex_ld_i  in  1  instruction is a load
ex_st_i  in  1  instruction is a store (never both with ld)
ex_funct3_i  in  3  RV32I funct3 of the memory op
ex_addr_i  in  32  effective byte address
ex_wdata_i  in  32  rs2 store data (unaligned, low lanes)
ex_rd_i  in  5  load destination register
lsu_stall_o  out  1  freeze IF..EX/MEM this cycle
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  memory accepts request this cycle
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read word
wb_valid_o  out  1  load result valid (1-cycle pulse)
wb_rd_o  out  5  load destination
wb_data_o  out  32  extended load data
misalign_o  out  1  misaligned access trap pulse

Behaviour:
- Reset: all outputs 0. State is IDLE. Outstanding access is abandoned; the memory side is reset on the same rst.
- FSM states: IDLE, REQ, RESP.
  - IDLE: a new access is ex_valid_i & (ex_ld_i|ex_st_i) & legal funct3.
    - lsu_stall_o=1 combinationally in the same cycle.
    - Op, lanes and rd are latched at the edge; go to REQ.
    - Illegal funct3 (load 011/110/111; store >=011): no access, no stall.
  - REQ: dmem_req_o=1; addr/we/be/wdata stable until the grant.
    - Store: on dmem_gnt_i, go to IDLE; lsu_stall_o=0 in the grant cycle.
    - Load: on gnt, go to RESP; stall stays 1.
  - RESP: stall=1 until dmem_rvalid_i. In the rvalid cycle stall=0 and go to IDLE.
    - Next edge registers wb_valid_o=1 (one cycle), plus wb_rd_o and wb_data_o.
- Store lanes:
  - SB: be=1<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011; wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load extraction:
  - LB/LBU: byte addr[1:0].
  - LH/LHU: halfword addr[1].
  - Sign-extend LB/LH; zero-extend LBU/LHU. dmem_be_o for loads mirrors the store pattern.
- Minimum latency:
  - store: 1 cycle of stall, with 1 REQ cycle if gnt is immediate;
  - load: 2 stall cycles, gnt then rvalid the next cycle.
- rvalid in IDLE/REQ is ignored. Memory guarantees rvalid is at least 1 cycle after gnt.
- Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. Handling depends on the macro below.
- rst asserted during REQ/RESP returns to IDLE at once. No wb_valid_o is produced for the abandoned load.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access is not issued; FSM stays IDLE, no stall.
  - misalign_o is registered high for 1 cycle. No writeback.
- Not defined:
  - Misaligned addresses are truncated to natural alignment (addr[0] or addr[1:0] cleared) and the access proceeds normally.
  - misalign_o tied 0.

Decomposition:
- Package rv_lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010;
  - FSM state enum.
- Sub-module lsu_load_align: combinational extract and sign/zero-extend, inputs funct3 + addr[1:0] + rdata.

Test Plan:
1. SW 0x1234ABCD to 0x190, gnt immediate -> dmem_req_o 1 cycle, addr 0x190, be 1111, wdata 0x1234ABCD, stall exactly 1 cycle.
2. Word 0x1234ABCD at 0x100:
   - LW 0x100 -> 0x1234ABCD;
   - LH/LHU 0x102 -> 0x00001234;
   - LH 0x100 -> 0xFFFFABCD;
   - LHU 0x100 -> 0x0000ABCD.
3. Same word:
   - LB/LBU 0x102 -> 0x00000034;
   - LB 0x100 -> 0xFFFFFFCD;
   - LBU 0x100 -> 0x000000CD;
   - wb_rd_o matches ex_rd_i.
4. SB 0x000000CD to 0x103 -> be 1000, wdata 0xCDCDCDCD. SH 0x0000ABCD to 0x102 -> be 1100, wdata 0xABCDABCD.
5. Load with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> req/addr stable through REQ, stall held until the rvalid cycle, single wb_valid_o pulse.
6. rst pulsed in RESP, then late rvalid -> outputs 0 and IDLE immediately, no wb_valid_o. With LSU_MISALIGN_TRAP_EN, LW 0x102 -> misalign_o pulse, no dmem_req_o.
